// File: rtl/alm_pkg.sv
// Shared definitions for the ALM_SOA5 product accumulator: product width,
// accumulator state encoding and the saturation ceiling helper.
package alm_pkg;

   localparam int ALM_PROD_W = 16;

   typedef enum logic {ACCUM, HOLD} alm_acc_state_t;

   // All-ones value of the given width (1..64), used as the clamp ceiling.
   function automatic logic [63:0] sat_max(input int unsigned width);
      logic [63:0] ones;
      ones = '1;
      return ones >> (64 - width);
   endfunction

endpackage

// File: rtl/alm_sat_add.sv
// Combinational saturating add of an unsigned product onto the running sum.
// The true sum is formed one bit wider so the carry-out flags the clamp.
module alm_sat_add
   import alm_pkg::*;
#(
   parameter int ACC_W  = 24,
   parameter int PROD_W = ALM_PROD_W
)
(
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'(sat_max(ACC_W));

   logic [ACC_W:0] full;

   always_comb begin
      full = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
      ovf  = full[ACC_W];
      sum  = ovf ? MAX_VAL : full[ACC_W-1:0];
   end

endmodule

// File: rtl/alm_dot_acc.sv
// Accumulates LEN multiplier products into one saturating unsigned sum and
// presents each finished sum on a valid/ready port.
module alm_dot_acc
   import alm_pkg::*;
#(
   parameter int PROD_W = ALM_PROD_W,
   parameter int ACC_W  = 24,
   parameter int LEN    = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [PROD_W-1:0] p_in,
   input  logic              p_valid,
   output logic              p_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic              sat
);

   localparam int CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

   alm_acc_state_t   state_reg, state_next;
   logic [ACC_W-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             sat_reg, sat_next;
   logic [ACC_W-1:0] acc_out_reg, acc_out_next;
   logic             sat_out_reg, sat_out_next;

   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;

   alm_sat_add #(
      .ACC_W  (ACC_W),
      .PROD_W (PROD_W)
   ) u_sat_add (
      .a   (acc_reg),
      .b   (p_in),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ACCUM;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         sat_reg     <= 1'b0;
         acc_out_reg <= '0;
         sat_out_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         sat_reg     <= sat_next;
         acc_out_reg <= acc_out_next;
         sat_out_reg <= sat_out_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      sat_next     = sat_reg;
      acc_out_next = acc_out_reg;
      sat_out_next = sat_out_reg;
      case (state_reg)
         ACCUM: begin
            // clr wins over an accept in the same cycle; that product is dropped.
            if (clr) begin
               acc_next = '0;
               cnt_next = '0;
               sat_next = 1'b0;
            end else if (p_valid) begin
               if (cnt_reg == LAST_CNT) begin
                  acc_out_next = add_sum;
                  sat_out_next = sat_reg | add_ovf;
                  acc_next     = '0;
                  cnt_next     = '0;
                  sat_next     = 1'b0;
                  state_next   = HOLD;
               end else begin
                  acc_next = add_sum;
                  cnt_next = cnt_reg + 1'b1;
                  sat_next = sat_reg | add_ovf;
               end
            end
         end
         HOLD: begin
            if (acc_ready) begin
               sat_out_next = 1'b0;
               state_next   = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   assign p_ready   = (state_reg == ACCUM);
   assign acc_valid = (state_reg == HOLD);
   assign acc_out   = acc_out_reg;
   assign sat       = sat_out_reg;

endmodule

// File: tb/tb_alm_dot_acc.sv
// Three accumulator instances (LEN=4/ACC_W=16, LEN=3/ACC_W=24, LEN=1/ACC_W=16)
// share one stimulus stream; each is tracked by its own behavioural model.
module tb_alm_dot_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        p_valid = 1'b0;
   logic        acc_ready = 1'b0;
   logic [15:0] p_in = '0;

   logic        p_ready_w[3];
   logic        acc_valid_w[3];
   logic        sat_w[3];
   logic [15:0] out0;
   logic [23:0] out1;
   logic [15:0] out2;

   int n_pass  = 0;
   int n_total = 0;

   int     len_c[3] = '{4, 3, 1};
   longint max_c[3] = '{65535, 16777215, 65535};

   // Model: a vector is just the list of accepted products; its result is
   // min(true total, max) and sat is whether the true total exceeded max.
   bit     hold_m[3];
   longint tot_m[3];
   int     cnt_m[3];
   longint out_m[3];
   bit     sat_m[3];

   always #5 clk = ~clk;

   alm_dot_acc #(.PROD_W(16), .ACC_W(16), .LEN(4)) dut0 (
      .clk(clk), .rst(rst), .clr(clr), .p_in(p_in), .p_valid(p_valid),
      .p_ready(p_ready_w[0]), .acc_out(out0), .acc_valid(acc_valid_w[0]),
      .acc_ready(acc_ready), .sat(sat_w[0])
   );
   alm_dot_acc #(.PROD_W(16), .ACC_W(24), .LEN(3)) dut1 (
      .clk(clk), .rst(rst), .clr(clr), .p_in(p_in), .p_valid(p_valid),
      .p_ready(p_ready_w[1]), .acc_out(out1), .acc_valid(acc_valid_w[1]),
      .acc_ready(acc_ready), .sat(sat_w[1])
   );
   alm_dot_acc #(.PROD_W(16), .ACC_W(16), .LEN(1)) dut2 (
      .clk(clk), .rst(rst), .clr(clr), .p_in(p_in), .p_valid(p_valid),
      .p_ready(p_ready_w[2]), .acc_out(out2), .acc_valid(acc_valid_w[2]),
      .acc_ready(acc_ready), .sat(sat_w[2])
   );

   function automatic logic [63:0] obs_out(input int i);
      case (i)
         0:       return {48'd0, out0};
         1:       return {40'd0, out1};
         default: return {48'd0, out2};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         hold_m[i] = 1'b0;
         tot_m[i]  = 0;
         cnt_m[i]  = 0;
         out_m[i]  = 0;
         sat_m[i]  = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         if (!hold_m[i]) begin
            if (clr) begin
               tot_m[i] = 0;
               cnt_m[i] = 0;
            end else if (p_valid) begin
               tot_m[i] += longint'(p_in);
               cnt_m[i]++;
               if (cnt_m[i] == len_c[i]) begin
                  sat_m[i]  = (tot_m[i] > max_c[i]);
                  out_m[i]  = sat_m[i] ? max_c[i] : tot_m[i];
                  hold_m[i] = 1'b1;
                  tot_m[i]  = 0;
                  cnt_m[i]  = 0;
                  $display("result dut%0d: sum=%0h sat=%0b", i, out_m[i], sat_m[i]);
               end
            end
         end else if (acc_ready) begin
            hold_m[i] = 1'b0;
            sat_m[i]  = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("p_ready%0d", i),   {63'd0, p_ready_w[i]},   {63'd0, !hold_m[i]});
         chk($sformatf("acc_valid%0d", i), {63'd0, acc_valid_w[i]}, {63'd0, hold_m[i]});
         chk($sformatf("acc_out%0d", i),   obs_out(i),              64'(out_m[i]));
         chk($sformatf("sat%0d", i),       {63'd0, sat_w[i]},       {63'd0, sat_m[i]});
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      check_all();
      cycle();
      rst = 1'b0;
   endtask

   task automatic feed(input logic [15:0] v);
      p_valid = 1'b1;
      p_in    = v;
      cycle();
   endtask

   task automatic idle(input int n);
      p_valid = 1'b0;
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      logic [15:0] v;
      #3;
      do_reset();

      // 1: basic vector
      acc_ready = 1'b1;
      feed(1); feed(2); feed(3); feed(4);
      chk("t1_valid", {63'd0, acc_valid_w[0]}, 64'd1);
      chk("t1_sum", {48'd0, out0}, 64'd10);
      chk("t1_sat", {63'd0, sat_w[0]}, 64'd0);
      idle(2);

      // 2: saturation, then a clean vector
      do_reset();
      acc_ready = 1'b1;
      for (int k = 0; k < 4; k++) feed(16'hFFFF);
      chk("t2_sum", {48'd0, out0}, 64'h0FFFF);
      chk("t2_sat", {63'd0, sat_w[0]}, 64'd1);
      idle(1);
      for (int k = 0; k < 4; k++) feed(16'd1);
      chk("t2b_sum", {48'd0, out0}, 64'd4);
      chk("t2b_sat", {63'd0, sat_w[0]}, 64'd0);
      idle(2);

      // 3: backpressure in HOLD with p_valid held high
      do_reset();
      acc_ready = 1'b0;
      feed(10); feed(20); feed(30); feed(40);
      for (int k = 0; k < 5; k++) begin
         feed(55);
         chk("t3_stall", {63'd0, p_ready_w[0]}, 64'd0);
         chk("t3_hold", {48'd0, out0}, 64'd100);
      end
      acc_ready = 1'b1;
      feed(55);
      chk("t3_handoff", {63'd0, p_ready_w[0]}, 64'd1);
      feed(55); feed(1); feed(1); feed(1);
      chk("t3_sum", {48'd0, out0}, 64'd58);
      idle(2);

      // 4: bubbles on the LEN=3 instance
      do_reset();
      acc_ready = 1'b1;
      feed(5); idle(2); feed(7); idle(1);
      chk("t4_pre", {63'd0, acc_valid_w[1]}, 64'd0);
      feed(9);
      chk("t4_valid", {63'd0, acc_valid_w[1]}, 64'd1);
      chk("t4_sum", {40'd0, out1}, 64'd21);
      idle(2);

      // 5: clr mid-vector, then clr during HOLD
      do_reset();
      acc_ready = 1'b0;
      feed(100); feed(200);
      clr = 1'b1; feed(999); clr = 1'b0;
      feed(1); feed(2); feed(3); feed(4);
      clr = 1'b1; feed(7); feed(7); clr = 1'b0;
      chk("t5_valid", {63'd0, acc_valid_w[0]}, 64'd1);
      chk("t5_sum", {48'd0, out0}, 64'd10);
      acc_ready = 1'b1;
      idle(2);

      // 6: reset mid-vector and during HOLD
      feed(9); feed(9);
      do_reset();
      acc_ready = 1'b0;
      feed(3); feed(3); feed(3); feed(3);
      do_reset();
      chk("t6_rdy", {63'd0, p_ready_w[0]}, 64'd1);
      acc_ready = 1'b1;
      feed(2); feed(2); feed(2); feed(2);
      chk("t6_sum", {48'd0, out0}, 64'd8);
      idle(2);

      // Random traffic against the models
      for (int k = 0; k < 2000; k++) begin
         v = 16'($urandom);
         if ($urandom_range(0, 2) == 0) v = 16'hFF00 | {8'd0, v[7:0]};
         p_in      = v;
         p_valid   = ($urandom_range(0, 3) != 0);
         acc_ready = ($urandom_range(0, 2) != 0);
         clr       = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 399) == 0) do_reset();
         else cycle();
      end
      clr = 1'b0;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
